axil_reg_bank: RTL
==================

Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank, terminating one AXIL_IF Slave port. Provides NUM_REGS bus-visible words with per-register read-only/read-write mode, byte-strobe writes and error responses. Exposes the register contents plus access pulses to the local logic. It is the generic control/status block placed behind every AXI-Lite master in the design.

Parameters:
ADDR_WIDTH, 12, address width; must equal the connected AXIL_IF ADDR_WIDTH.
DATA_WIDTH, 32, data width (32 or 64); must equal the AXIL_IF DATA_WIDTH.
NUM_REGS, 16, number of registers (1..256); requires NUM_REGS*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
RO_MASK, '0 (NUM_REGS bits), bit i=1 makes register i read-only, sourced from hw_in.
RESET_VALUE, '0 (DATA_WIDTH bits), reset value of every RW register.

Ports:
aclk  input  1  clock; the only clock.
aresetn  input  1  synchronous, active-low reset.
s_axil  interface  AXIL_IF.Slave  AXI-Lite slave port (aw/w/b/ar/r channels).
reg_q  output  NUM_REGS*DATA_WIDTH  current register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
hw_in  input  NUM_REGS*DATA_WIDTH  status inputs; only the RO slices are used.
wr_pulse  output  NUM_REGS  1-cycle pulse per successful write to RW register i.
rd_pulse  output  NUM_REGS  1-cycle pulse per successful read of register i.

Behaviour:
- Interface decision: one clock, aclk. Reset aresetn is synchronous and active-low.
- Reset, sampled on the aclk edge: RW regs = RESET_VALUE; RO shadows = 0.
- Reset outputs: awready, wready, arready, bvalid and rvalid = 0. bresp, rresp and rdata = 0. wr_pulse and rd_pulse = 0.
- First cycle after aresetn rises: awready = wready = arready = 1.
- Reset mid-transaction: any captured-but-uncommitted AW/W is dropped and any pending B/R response is discarded. No register changes.
- Address decode: index = addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. awprot and arprot are ignored.
- Write channel, AW and W accepted independently in any order:
  - awready stays high until AW is captured; wready stays high until W is captured.
  - Once both are captured, both readies drop until the B handshake completes.
  - Commit happens on the edge that completes the second handshake, or the single edge if both complete together.
  - bvalid rises the next cycle and is held, with bresp stable, until bready.
  - awready and wready return high the cycle after the B handshake.
  - Throughput: one write every 2 cycles when bready is held high.
- Write commit:
  - Legal RW index: each byte lane with wstrb=1 is updated; other lanes hold.
  - bresp = OKAY (2'b00). wr_pulse[index] is high for exactly the first bvalid cycle.
  - index >= NUM_REGS, or RO register: no state change, bresp = SLVERR (2'b10), no wr_pulse.
  - wstrb = 0 to a legal RW register: OKAY, no change, wr_pulse still fires.
- Read channel:
  - arready = 1 whenever rvalid = 0.
  - On the AR handshake edge, rdata and rresp are captured from pre-edge state and rvalid rises.
  - rdata and rresp are held stable until rready; arready returns high the cycle after the R handshake.
  - rd_pulse[index] is high for the first rvalid cycle.
  - index >= NUM_REGS: rdata = 0, rresp = SLVERR, no rd_pulse.
- RO registers: the shadow register samples hw_in every cycle; reg_q and reads return the shadow (1-cycle delay from hw_in).
- Read/write ordering: the read and write paths are independent.
  - A read handshake on the same edge as a write commit to the same register returns the old value.
  - A read handshake one cycle later returns the new value.
- Without bready/rready, the block never drops or reorders a response. Only one outstanding transaction per direction.

Test Plan:
- Reset with RESET_VALUE=32'hA5A5_0000. Read reg 3 -> rdata=32'hA5A5_0000, rresp=00, rvalid one cycle after the AR handshake, rd_pulse[3] high for one cycle.
- AW (addr 0x008) on cycle 0, W (32'h1234_5678, wstrb=4'hF) on cycle 3 -> bvalid rises on cycle 4, bresp=00, reg_q slice 2 = 32'h1234_5678, wr_pulse[2] high on cycle 4 only.
- Reg 1 = 32'hFFFF_FFFF, then write 32'h0000_0000 with wstrb=4'b0101 -> reg 1 = 32'hFF00_FF00.
- Write to index 20 (NUM_REGS=16), and a write to RO reg 0 -> both bresp=10, no reg_q change. Read index 20 -> rdata=0, rresp=10.
- Hold bready=0 for 5 cycles after bvalid -> bvalid and bresp held, awready=wready=0 throughout. A second AW is accepted the cycle after the B handshake.
- hw_in slice 0 (RO) = 32'hDEAD_BEEF -> reg_q slice 0 and a read return 32'hDEAD_BEEF. Deassert aresetn while rvalid=1 -> rvalid=0 on the next edge, all RW regs return to RESET_VALUE.

Source files
------------

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle shared by every control/status register bank and its master.
// The Slave modport is the register-bank side of the bus.
interface AXIL_IF #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_bank.sv
// Generic AXI4-Lite register bank: NUM_REGS words, each either read-write with byte
// strobes or a read-only shadow of hw_in, with per-register access pulses.
module axil_reg_bank #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    AXIL_IF.Slave                          s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDXW   = ADDR_WIDTH - SHIFT;
    localparam int SELW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  awready_reg, wready_reg, bvalid_reg;
    logic                  arready_reg, rvalid_reg;
    logic                  aw_done_reg, w_done_reg;
    logic [IDXW-1:0]       widx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;
    logic [1:0]            bresp_reg, rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg, rd_pulse_reg;
    logic [DATA_WIDTH-1:0] cur [NUM_REGS];

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  commit, w_inrange, w_legal, r_inrange;
    logic [IDXW-1:0]       widx, ridx;
    logic [SELW-1:0]       wsel, rsel;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [STRB_W-1:0]     wstrb_c;

    assign aw_hs = s_axil.awvalid && awready_reg;
    assign w_hs  = s_axil.wvalid  && wready_reg;
    assign b_hs  = bvalid_reg     && s_axil.bready;
    assign ar_hs = s_axil.arvalid && arready_reg;
    assign r_hs  = rvalid_reg     && s_axil.rready;

    // The second half of a write may arrive on the committing edge, so pick live or captured.
    always_comb begin
        widx      = aw_done_reg ? widx_reg  : s_axil.awaddr[ADDR_WIDTH-1:SHIFT];
        wdata_c   = w_done_reg  ? wdata_reg : s_axil.wdata;
        wstrb_c   = w_done_reg  ? wstrb_reg : s_axil.wstrb;
        wsel      = widx[SELW-1:0];
        commit    = (aw_hs || aw_done_reg) && (w_hs || w_done_reg);
        w_inrange = 32'(widx) < NUM_REGS;
        w_legal   = w_inrange && !RO_MASK[wsel];
        ridx      = s_axil.araddr[ADDR_WIDTH-1:SHIFT];
        rsel      = ridx[SELW-1:0];
        r_inrange = 32'(ridx) < NUM_REGS;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            widx_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= '0;
            if (aw_hs) begin
                aw_done_reg <= 1'b1;
                widx_reg    <= s_axil.awaddr[ADDR_WIDTH-1:SHIFT];
            end
            if (w_hs) begin
                w_done_reg <= 1'b1;
                wdata_reg  <= s_axil.wdata;
                wstrb_reg  <= s_axil.wstrb;
            end
            if (commit) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= w_legal ? RESP_OKAY : RESP_SLVERR;
                if (w_legal)
                    wr_pulse_reg[wsel] <= 1'b1;
            end else if (b_hs) begin
                bvalid_reg <= 1'b0;
            end
            awready_reg <= b_hs ? 1'b1 : (aw_hs ? 1'b0 : (!aw_done_reg && !bvalid_reg));
            wready_reg  <= b_hs ? 1'b1 : (w_hs  ? 1'b0 : (!w_done_reg  && !bvalid_reg));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            rd_pulse_reg <= '0;
        end else begin
            rd_pulse_reg <= '0;
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                if (r_inrange) begin
                    rdata_reg          <= cur[rsel];
                    rresp_reg          <= RESP_OKAY;
                    rd_pulse_reg[rsel] <= 1'b1;
                end else begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end else if (r_hs) begin
                rvalid_reg <= 1'b0;
            end
            arready_reg <= r_hs ? 1'b1 : (ar_hs ? 1'b0 : !rvalid_reg);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] q_reg;
            if (RO_MASK[gi]) begin : g_ro
                always_ff @(posedge aclk) begin
                    if (!aresetn)
                        q_reg <= '0;
                    else
                        q_reg <= hw_in[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end else begin : g_rw
                always_ff @(posedge aclk) begin
                    if (!aresetn) begin
                        q_reg <= RESET_VALUE;
                    end else if (commit && w_inrange && widx == IDXW'(gi)) begin
                        for (int b = 0; b < STRB_W; b++)
                            if (wstrb_c[b])
                                q_reg[b*8 +: 8] <= wdata_c[b*8 +: 8];
                    end
                end
            end
            assign cur[gi] = q_reg;
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
        end
    endgenerate

    assign s_axil.awready = awready_reg;
    assign s_axil.wready  = wready_reg;
    assign s_axil.bvalid  = bvalid_reg;
    assign s_axil.bresp   = bresp_reg;
    assign s_axil.arready = arready_reg;
    assign s_axil.rvalid  = rvalid_reg;
    assign s_axil.rdata   = rdata_reg;
    assign s_axil.rresp   = rresp_reg;
    assign wr_pulse       = wr_pulse_reg;
    assign rd_pulse       = rd_pulse_reg;

    // Protection bits, byte offsets and the RW slices of hw_in carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axil.awprot, s_axil.arprot, s_axil.awaddr[SHIFT-1:0],
                         s_axil.araddr[SHIFT-1:0], hw_in};
endmodule
